satadd_pipe: RTL and testbench
==============================

// Module: satadd_pipe
// PURPOSE
//   Parametrised, pipelined saturating adder/accumulator; next generation of the lab03 12-bit adder.
//   Accepts operand beats on a valid/ready stream and returns a clamped or wrapped sum two cycles later.
//   Adds a running accumulator, per-result overflow flag and optional sticky overflow status.
//   Sits between a producer stream and a downstream consumer in the datapath.
// PARAMETERS
//   WIDTH   12   operand/result width in bits (>=4)
// PORTS
//   clk          in   1      rising-edge clock, single clock domain
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      operand beat valid
//   in_ready     out  1      block can accept a beat
//   in_a         in   WIDTH  operand A
//   in_b         in   WIDTH  operand B (ignored by ACC/LOAD)
//   in_mode      in   2      00 unsigned sat, 01 signed sat, 1x wrap
//   in_op        in   2      00 ADD a+b, 01 ACC acc+a, 10 LOAD a, 11 treated as ADD
//   out_valid    out  1      result valid
//   out_ready    in   1      consumer accepts result
//   out_y        out  WIDTH  result
//   out_ovf      out  1      this result was clamped
//   sticky_ovf   out  1      any clamp since last clear (see CONFIGURATION)
//   clr_sticky   in   1      synchronous clear of sticky_ovf
// BEHAVIOUR
// - Reset (async, rst_n=0): s1_valid, out_valid, out_y, out_ovf, sticky_ovf, acc all 0; in_ready 1 after release.
//   Reset mid-stream discards all in-flight beats; no partial result is ever presented.
// - Handshake: beat accepted when in_valid & in_ready; result consumed when out_valid & out_ready.
//   out_y/out_ovf stable while out_valid & !out_ready. in_ready independent of in_valid.
// - Pipeline: stage S1 (compute+saturate, registered), stage S2 (output register = out_*).
//   S2 loads when empty or consumed in the same cycle; S1 advances into S2 under that rule.
//   in_ready = !s1_valid | s2_load. Latency 2 cycles with no backpressure; throughput 1 beat/cycle.
//   Full (both stages valid, out_ready=0): in_ready=0, nothing lost or duplicated.
// - Arithmetic: r = {1'b0,x} + {1'b0,y}, WIDTH+1 bits; x = (op==ACC ? acc : in_a), y = (op==ACC ? in_a : in_b).
//   Unsigned sat: r[WIDTH]=1 -> all ones, ovf=1.
//   Signed sat: x,y same sign and r[WIDTH-1] differs -> x[MSB] ? 100..0 : 011..1, ovf=1.
//   Wrap: r[WIDTH-1:0], ovf=0. LOAD: result=in_a, ovf=0, mode ignored.
// - Accumulator: acc <= S1 result on every accepted beat, same edge (back-to-back ACC beats see prior result, no bubble).
// - Sticky: set when an S1 result with ovf=1 is captured; clr_sticky clears. Simultaneous set and clear: set wins.
// CONFIGURATION
//   SATADD_PIPE_STICKY_EN defined: sticky_ovf as above.
//   Undefined: sticky_ovf tied 0, clr_sticky ignored, no sticky register; all else identical.
// STRUCTURE
//   Package satadd_pkg: localparams MODE_USAT=2'b00, MODE_SSAT=2'b01, MODE_WRAP=2'b10;
//   OP_ADD=2'b00, OP_ACC=2'b01, OP_LOAD=2'b10; 2-bit mode/op typedefs.
//   Sub-module satadd_sat_core (combinational, WIDTH param): x,y,mode -> result, ovf.
//   satadd_pipe holds handshake, S1/S2 registers, acc, sticky.
// TESTING (WIDTH=12)
//   1. SSAT ADD 0x7FF+0x001 -> y=0x7FF ovf=1; 0x800+0xFFF -> y=0x800 ovf=1; 0x7FE+0x001 -> 0x7FF ovf=0.
//   2. USAT ADD 0xFFF+0x001 -> 0xFFF ovf=1; WRAP 0xFFF+0x002 -> 0x001 ovf=0.
//   3. LOAD 0x100 then ACC a=0x300 x3 back-to-back (SSAT) -> 0x100,0x400,0x700,0x7FF(ovf=1); outputs on consecutive cycles.
//   4. Stream 8 beats with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted; all 8 results in order, none lost.
//   5. Overflow beat then clr_sticky same cycle as another ovf capture -> sticky_ovf stays 1; lone clear -> 0 (macro on); always 0 (macro off).
//   6. Assert rst_n=0 with both stages full -> out_valid=0, acc=0 immediately; next ACC a=0x005 -> 0x005.

Source files
------------

// File: rtl/satadd_pkg.sv
// Shared mode/op encodings for the saturating adder pipeline.
package satadd_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] op_t;

  localparam mode_t MODE_USAT = 2'b00;
  localparam mode_t MODE_SSAT = 2'b01;
  localparam mode_t MODE_WRAP = 2'b10;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_ACC  = 2'b01;
  localparam op_t OP_LOAD = 2'b10;

  // Any mode with the upper bit set wraps.
  function automatic logic is_wrap(input mode_t m);
    return m[1];
  endfunction

endpackage

// File: rtl/satadd_sat_core.sv
// Combinational add with unsigned/signed clamp or wrap; ovf flags a clamped result.
// Latency 0; no flow control.
module satadd_sat_core
  import satadd_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  mode_t            mode,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH:0] r;

  always_comb begin
    r      = {1'b0, x} + {1'b0, y};
    result = r[WIDTH-1:0];
    ovf    = 1'b0;
    if (!is_wrap(mode)) begin
      if (mode == MODE_SSAT) begin
        // Overflow only possible when both operands share a sign.
        if ((x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1])) begin
          ovf    = 1'b1;
          result = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end else if (r[WIDTH]) begin
        ovf    = 1'b1;
        result = '1;
      end
    end
  end

endmodule

// File: rtl/satadd_pipe.sv
// Two-stage saturating adder/accumulator on valid/ready streams; latency 2, 1 beat/cycle.
// Backpressure: S2 holds while out_ready low, S1 fills, then in_ready drops. Sticky via SATADD_PIPE_STICKY_EN.
module satadd_pipe
  import satadd_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_ovf,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_y;
  logic             s1_ovf;
  logic [WIDTH-1:0] acc;
  logic             s2_load;
  logic             accept;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] core_y;
  logic             core_ovf;
  logic [WIDTH-1:0] res_y;
  logic             res_ovf;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  assign op_x = (in_op == OP_ACC) ? acc  : in_a;
  assign op_y = (in_op == OP_ACC) ? in_a : in_b;

  satadd_sat_core #(.WIDTH(WIDTH)) u_core (
    .x      (op_x),
    .y      (op_y),
    .mode   (in_mode),
    .result (core_y),
    .ovf    (core_ovf)
  );

  always_comb begin
    res_y   = core_y;
    res_ovf = core_ovf;
    if (in_op == OP_LOAD) begin
      res_y   = in_a;
      res_ovf = 1'b0;
    end
  end

  // S1 only changes when it is empty or draining into S2 this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_ovf   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= accept;
      if (accept) begin
        s1_y   <= res_y;
        s1_ovf <= res_ovf;
      end
    end
  end

  // Accumulator tracks the S1 result at capture so back-to-back ACC beats chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept) begin
      acc <= res_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y   <= s1_y;
        out_ovf <= s1_ovf;
      end
    end
  end

`ifdef SATADD_PIPE_STICKY_EN
  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (accept && res_ovf) begin
      sticky_ovf <= 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
    end
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_satadd_pipe.sv
// Scoreboard bench for satadd_pipe (WIDTH=12): directed vectors, decoupled monitor.
module tb_satadd_pipe;
  import satadd_pkg::*;

  localparam int W = 12;
`ifdef SATADD_PIPE_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_mode = 2'b00;
  logic [1:0]   in_op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic         out_ovf;
  logic         sticky_ovf;
  logic         clr_sticky = 1'b0;

  satadd_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_ovf    (out_ovf),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: one pop per consumed result; sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected no result", out_y);
      end else begin
        mon_e = sb.pop_front();
        chk("out_y", {20'd0, out_y}, {20'd0, mon_e.y});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, mon_e.ovf});
        if (mon_e.lat) chk("latency", cycle - mon_e.cyc, 2);
        pop_cyc.push_back(cycle);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                      input logic [1:0] op, input logic [W-1:0] ey, input logic eovf, input bit lat);
    int   t;
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_op    = op;
    t        = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end else begin
      e.y   = ey;
      e.ovf = eovf;
      e.cyc = cycle;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_y", {20'd0, out_y}, 0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 0);
    chk("rst_sticky", {31'd0, sticky_ovf}, 0);
    rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // 1. Signed saturation
    send(12'h7FF, 12'h001, MODE_SSAT, OP_ADD, 12'h7FF, 1'b1, 1'b1);
    send(12'h800, 12'hFFF, MODE_SSAT, OP_ADD, 12'h800, 1'b1, 1'b1);
    send(12'h7FE, 12'h001, MODE_SSAT, OP_ADD, 12'h7FF, 1'b0, 1'b1);
    // 2. Unsigned saturation and wrap
    send(12'hFFF, 12'h001, MODE_USAT, OP_ADD, 12'hFFF, 1'b1, 1'b1);
    send(12'hFFF, 12'h002, MODE_WRAP, OP_ADD, 12'h001, 1'b0, 1'b1);
    drain();

    // 3. LOAD then back-to-back ACC, consecutive outputs
    pop_cyc.delete();
    send(12'h100, 12'hABC, MODE_SSAT, OP_LOAD, 12'h100, 1'b0, 1'b1);
    send(12'h300, 12'h000, MODE_SSAT, OP_ACC,  12'h400, 1'b0, 1'b1);
    send(12'h300, 12'h000, MODE_SSAT, OP_ACC,  12'h700, 1'b0, 1'b1);
    send(12'h300, 12'h000, MODE_SSAT, OP_ACC,  12'h7FF, 1'b1, 1'b1);
    drain();
    chk("acc_pop_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4)
      for (int i = 0; i < 3; i++) chk("acc_consecutive", pop_cyc[i+1] - pop_cyc[i], 1);

    // 4. Backpressure: 8 beats, consumer stalled
    pop_cyc.delete();
    out_ready = 1'b0;
    send(12'h001, 12'h002, MODE_WRAP, 2'b11,   12'h003, 1'b0, 1'b0);
    send(12'h020, 12'h002, 2'b11,     OP_ADD,  12'h022, 1'b0, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    chk("full_out_valid", {31'd0, out_valid}, 1);
    chk("full_out_y_held", {20'd0, out_y}, 12'h003);
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        send(12'hFF0, 12'h020, MODE_WRAP, OP_ADD, 12'h010, 1'b0, 1'b0);
        send(12'h800, 12'h800, MODE_WRAP, OP_ADD, 12'h000, 1'b0, 1'b0);
        send(12'h123, 12'h456, MODE_USAT, OP_ADD, 12'h579, 1'b0, 1'b0);
        send(12'hF00, 12'h200, MODE_USAT, OP_ADD, 12'hFFF, 1'b1, 1'b0);
        send(12'h400, 12'h400, MODE_SSAT, OP_ADD, 12'h7FF, 1'b1, 1'b0);
        send(12'hC00, 12'h100, MODE_SSAT, OP_ADD, 12'hD00, 1'b0, 1'b0);
      end
    join
    drain();
    chk("bp_pop_count", pop_cyc.size(), 8);

    // 5. Sticky overflow
    clr_sticky = 1'b1;
    idle(1);
    clr_sticky = 1'b0;
    chk("sticky_clr0", {31'd0, sticky_ovf}, 0);
    send(12'hFFF, 12'h001, MODE_USAT, OP_ADD, 12'hFFF, 1'b1, 1'b1);
    chk("sticky_set", {31'd0, sticky_ovf}, {31'd0, STK});
    drain();
    chk("sticky_hold", {31'd0, sticky_ovf}, {31'd0, STK});
    clr_sticky = 1'b1;
    send(12'hFFF, 12'h00F, MODE_USAT, OP_ADD, 12'hFFF, 1'b1, 1'b1);
    clr_sticky = 1'b0;
    chk("sticky_set_wins", {31'd0, sticky_ovf}, {31'd0, STK});
    drain();
    clr_sticky = 1'b1;
    idle(1);
    clr_sticky = 1'b0;
    chk("sticky_lone_clr", {31'd0, sticky_ovf}, 0);

    // 6. Reset with both stages full
    out_ready = 1'b0;
    send(12'h001, 12'h001, MODE_WRAP, OP_ADD, 12'h002, 1'b0, 1'b0);
    send(12'h002, 12'h002, MODE_WRAP, OP_ADD, 12'h004, 1'b0, 1'b0);
    chk("prerst_in_ready", {31'd0, in_ready}, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_out_y", {20'd0, out_y}, 0);
    chk("midrst_sticky", {31'd0, sticky_ovf}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    chk("postrst_in_ready", {31'd0, in_ready}, 1);
    chk("postrst_out_valid", {31'd0, out_valid}, 0);
    send(12'h005, 12'h000, MODE_SSAT, OP_ACC, 12'h005, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
